// File: rtl/condicionador_botoes_prova_if.sv
// Button conditioner bundle: raw button levels and control in, conditioned play out.
// The master side (datapath / bench) drives the inputs; the slave side is the conditioner.
interface condicionador_botoes_prova_if;
   logic [15:0] botoes;
   logic        habilita;
   logic        zera;
   logic [15:0] jogada;
   logic [3:0]  jogada_codigo;
   logic        jogada_pulso;
   logic        erro_multiplo;
   logic [3:0]  db_estado;

   modport master (
      output botoes, habilita, zera,
      input  jogada, jogada_codigo, jogada_pulso, erro_multiplo, db_estado
   );

   modport slave (
      input  botoes, habilita, zera,
      output jogada, jogada_codigo, jogada_pulso, erro_multiplo, db_estado
   );
endinterface

// File: rtl/condicionador_botoes_prova.sv
// Synchronises and debounces the 16-button vector as a whole. Each clean single-button
// press is delivered once as a one-hot play, its code and a strobe; multi-presses are flagged.
module condicionador_botoes_prova #(
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int CONT_W          = 16
) (
   input logic                         clock,
   input logic                         reset,
   condicionador_botoes_prova_if.slave bus
);

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      ESTABILIZA  = 4'd1,
      VALIDA      = 4'd2,
      PRESSIONADO = 4'd3,
      SOLTA       = 4'd4,
      MULTIPLO    = 4'd5
   } estado_t;

   localparam logic [CONT_W-1:0] CONT_FIM = CONT_W'(DEBOUNCE_CICLOS - 1);

   estado_t           estado, proximo;
   logic [15:0]       sinc1, s, amostra;
   logic [CONT_W-1:0] contador;
   logic [15:0]       jogada_r;
   logic [3:0]        codigo_r;
   logic              erro_r;
   logic              captura, zera_cont, incrementa, carrega, marca_erro;
   logic              fim_contagem, amostra_unica;
   logic [3:0]        codigo_amostra;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sinc1 <= '0;
         s     <= '0;
      end else begin
         sinc1 <= bus.botoes;
         s     <= sinc1;
      end
   end

   // A non-zero vector with no bit left after clearing its lowest set bit is one-hot.
   assign fim_contagem  = (contador == CONT_FIM);
   assign amostra_unica = (amostra != '0) && ((amostra & (amostra - 16'd1)) == '0);

   always_comb begin
      codigo_amostra = '0;
      for (int k = 0; k < 16; k++) begin
         if (amostra[k]) codigo_amostra = 4'(k);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= INICIAL;
      else       estado <= proximo;
   end

   always_comb begin
      proximo    = estado;
      captura    = 1'b0;
      zera_cont  = 1'b0;
      incrementa = 1'b0;
      carrega    = 1'b0;
      marca_erro = 1'b0;
      case (estado)
         INICIAL: begin
            if (s != '0) begin
               if (bus.habilita) begin
                  captura   = 1'b1;
                  zera_cont = 1'b1;
                  proximo   = ESTABILIZA;
               end else begin
                  proximo = PRESSIONADO;
               end
            end
         end
         ESTABILIZA: begin
            if (s != amostra)       proximo = INICIAL;
            else if (!bus.habilita) proximo = PRESSIONADO;
            else if (fim_contagem) begin
               if (amostra_unica) begin
                  carrega = 1'b1;
                  proximo = VALIDA;
               end else begin
                  marca_erro = 1'b1;
                  proximo    = MULTIPLO;
               end
            end else begin
               incrementa = 1'b1;
            end
         end
         VALIDA: proximo = PRESSIONADO;
         PRESSIONADO, MULTIPLO: begin
            if (s == '0) begin
               zera_cont = 1'b1;
               proximo   = SOLTA;
            end
         end
         // Any non-zero sample during the release window is a bounce back to pressed.
         SOLTA: begin
            if (s != '0)          proximo = PRESSIONADO;
            else if (fim_contagem) proximo = INICIAL;
            else                   incrementa = 1'b1;
         end
         default: proximo = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         amostra  <= '0;
         contador <= '0;
      end else begin
         if (captura) amostra <= s;
         if (zera_cont)       contador <= '0;
         else if (incrementa) contador <= contador + 1'b1;
      end
   end

   // zera wins over a load on the same edge; the FSM still emits the pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         jogada_r <= '0;
         codigo_r <= '0;
         erro_r   <= 1'b0;
      end else if (bus.zera) begin
         jogada_r <= '0;
         codigo_r <= '0;
         erro_r   <= 1'b0;
      end else begin
         if (carrega) begin
            jogada_r <= amostra;
            codigo_r <= codigo_amostra;
            erro_r   <= 1'b0;
         end
         if (marca_erro) erro_r <= 1'b1;
      end
   end

   assign bus.jogada        = jogada_r;
   assign bus.jogada_codigo = codigo_r;
   assign bus.erro_multiplo = erro_r;
   assign bus.jogada_pulso  = (estado == VALIDA);
   assign bus.db_estado     = estado;

endmodule

// File: tb/tb_condicionador_botoes_prova.sv
// Bench for condicionador_botoes_prova: reset checks, a vector table for a clean press,
// directed corner sequences and randomized traffic against a run-length reference model.
module tb_condicionador_botoes_prova;

   localparam int D = 4;

   logic clock = 1'b0;
   logic reset;

   condicionador_botoes_prova_if bus_if();

   condicionador_botoes_prova #(
      .DEBOUNCE_CICLOS(D),
      .CONT_W(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus_if.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] botoes;
      logic [15:0] exp_jogada;
      logic [3:0]  exp_codigo;
      logic        exp_pulso;
      logic [3:0]  exp_estado;
   } vec_t;

   int n_compared   = 0;
   int n_mismatched = 0;
   int pulse_cnt    = 0;

   // Reference model: two-sample delay, candidate run length and release zero-run.
   logic [15:0] m_s1, m_s2, m_cand, m_jogada;
   logic [3:0]  m_codigo;
   logic        m_pulso, m_erro, m_locked;
   int          m_zero_run, m_cand_len;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_cand = '0; m_jogada = '0; m_codigo = '0;
      m_pulso = 1'b0; m_erro = 1'b0; m_locked = 1'b0;
      m_zero_run = 0; m_cand_len = 0;
   endtask

   task automatic model_edge(input logic [15:0] b, input logic h, input logic z);
      logic [15:0] sv;
      logic        was_pulse;
      sv = m_s2; m_s2 = m_s1; m_s1 = b;
      was_pulse = m_pulso;
      m_pulso = 1'b0;
      if (was_pulse) begin
         m_locked = 1'b1; m_zero_run = 0;
      end else if (m_locked) begin
         if (sv == '0) begin
            m_zero_run++;
            if (m_zero_run == D + 1) m_locked = 1'b0;
         end else m_zero_run = 0;
      end else if (m_cand_len > 0) begin
         if (sv != m_cand) m_cand_len = 0;
         else if (!h) begin
            m_cand_len = 0; m_locked = 1'b1; m_zero_run = 0;
         end else if (m_cand_len == D) begin
            m_cand_len = 0; m_locked = 1'b1; m_zero_run = 0;
            if ($countones(m_cand) == 1) begin
               m_pulso = 1'b1; m_jogada = m_cand;
               m_codigo = 4'($clog2(m_cand)); m_erro = 1'b0;
            end else m_erro = 1'b1;
         end else m_cand_len++;
      end else if (sv != '0) begin
         if (h) begin m_cand = sv; m_cand_len = 1; end
         else begin m_locked = 1'b1; m_zero_run = 0; end
      end
      if (z) begin m_jogada = '0; m_codigo = '0; m_erro = 1'b0; end
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Called at a negedge: drive, take one posedge through the model, compare, return at negedge.
   task automatic applyStimulus(input logic [15:0] b, input logic h, input logic z);
      bus_if.botoes = b; bus_if.habilita = h; bus_if.zera = z;
      @(posedge clock);
      model_edge(b, h, z);
      #1;
      checkOutput("model_jogada", bus_if.jogada, m_jogada);
      checkOutput("model_codigo", {12'h0, bus_if.jogada_codigo}, {12'h0, m_codigo});
      checkOutput("model_pulso", {15'h0, bus_if.jogada_pulso}, {15'h0, m_pulso});
      checkOutput("model_erro", {15'h0, bus_if.erro_multiplo}, {15'h0, m_erro});
      if (bus_if.jogada_pulso) pulse_cnt++;
      @(negedge clock);
   endtask

   task automatic hold(input logic [15:0] b, input logic h, input int n);
      for (int i = 0; i < n; i++) applyStimulus(b, h, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_jogada"}, bus_if.jogada, 16'h0);
      checkOutput({tag, "_codigo"}, {12'h0, bus_if.jogada_codigo}, 16'h0);
      checkOutput({tag, "_pulso"}, {15'h0, bus_if.jogada_pulso}, 16'h0);
      checkOutput({tag, "_erro"}, {15'h0, bus_if.erro_multiplo}, 16'h0);
      checkOutput({tag, "_estado"}, {12'h0, bus_if.db_estado}, 16'h0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t        tabela [12];
      logic [15:0] v, one;
      logic        h, z;
      int          sel, len;

      one = 16'd1;
      for (int i = 0; i < 12; i++) begin
         tabela[i].botoes     = 16'h0020;
         tabela[i].exp_jogada = (i >= 6) ? 16'h0020 : 16'h0000;
         tabela[i].exp_codigo = (i >= 6) ? 4'd5 : 4'd0;
         tabela[i].exp_pulso  = (i == 6);
         tabela[i].exp_estado = (i < 2) ? 4'd0 : (i < 6) ? 4'd1 : (i == 6) ? 4'd2 : 4'd3;
      end

      bus_if.botoes = '0; bus_if.habilita = 1'b1; bus_if.zera = 1'b0;
      reset = 1'b1;
      model_reset();
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;

      // Clean press, edge by edge.
      pulse_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tabela[i].botoes, 1'b1, 1'b0);
         checkOutput($sformatf("tab%0d_jogada", i), bus_if.jogada, tabela[i].exp_jogada);
         checkOutput($sformatf("tab%0d_codigo", i), {12'h0, bus_if.jogada_codigo}, {12'h0, tabela[i].exp_codigo});
         checkOutput($sformatf("tab%0d_pulso", i), {15'h0, bus_if.jogada_pulso}, {15'h0, tabela[i].exp_pulso});
         checkOutput($sformatf("tab%0d_estado", i), {12'h0, bus_if.db_estado}, {12'h0, tabela[i].exp_estado});
      end
      hold(16'h0020, 1'b1, 8);
      checkOutput("limpo_pulsos", 16'(pulse_cnt), 16'd1);
      hold(16'h0, 1'b1, 10);

      // Bouncing press.
      pulse_cnt = 0;
      hold(16'h0100, 1'b1, 2); hold(16'h0, 1'b1, 2); hold(16'h0100, 1'b1, 2);
      checkOutput("bounce_sem_pulso", 16'(pulse_cnt), 16'd0);
      hold(16'h0100, 1'b1, 12);
      checkOutput("bounce_pulsos", 16'(pulse_cnt), 16'd1);
      checkOutput("bounce_codigo", {12'h0, bus_if.jogada_codigo}, 16'd8);
      hold(16'h0, 1'b1, 10);

      // Two buttons, then a valid single press.
      pulse_cnt = 0;
      hold(16'h0081, 1'b1, 10);
      checkOutput("multi_erro", {15'h0, bus_if.erro_multiplo}, 16'd1);
      checkOutput("multi_estado", {12'h0, bus_if.db_estado}, 16'd5);
      checkOutput("multi_jogada", bus_if.jogada, 16'h0100);
      checkOutput("multi_pulsos", 16'(pulse_cnt), 16'd0);
      hold(16'h0, 1'b1, 10);
      checkOutput("multi_solto_estado", {12'h0, bus_if.db_estado}, 16'd0);
      hold(16'h8000, 1'b1, 12);
      checkOutput("pos_multi_pulsos", 16'(pulse_cnt), 16'd1);
      checkOutput("pos_multi_codigo", {12'h0, bus_if.jogada_codigo}, 16'd15);
      checkOutput("pos_multi_erro", {15'h0, bus_if.erro_multiplo}, 16'd0);

      // Release with two glitches back to the pressed value.
      pulse_cnt = 0;
      applyStimulus(16'h0, 1'b1, 1'b0);
      applyStimulus(16'h0, 1'b1, 1'b0);
      applyStimulus(16'h8000, 1'b1, 1'b0);
      applyStimulus(16'h0, 1'b1, 1'b0);
      applyStimulus(16'h8000, 1'b1, 1'b0);
      hold(16'h0, 1'b1, 6);
      checkOutput("solta_estado", {12'h0, bus_if.db_estado}, 16'd4);
      applyStimulus(16'h0, 1'b1, 1'b0);
      checkOutput("solta_inicial", {12'h0, bus_if.db_estado}, 16'd0);
      checkOutput("solta_pulsos", 16'(pulse_cnt), 16'd0);

      // Press held while disabled is never accepted.
      pulse_cnt = 0;
      hold(16'h0004, 1'b0, 6);
      hold(16'h0004, 1'b1, 8);
      checkOutput("desab_pulsos", 16'(pulse_cnt), 16'd0);
      checkOutput("desab_estado", {12'h0, bus_if.db_estado}, 16'd3);
      hold(16'h0, 1'b1, 10);
      hold(16'h0004, 1'b1, 12);
      checkOutput("repress_pulsos", 16'(pulse_cnt), 16'd1);
      checkOutput("repress_codigo", {12'h0, bus_if.jogada_codigo}, 16'd2);

      // Asynchronous reset in the middle of debounce.
      hold(16'h0, 1'b1, 10);
      hold(16'h0010, 1'b1, 5);
      checkOutput("pre_reset_estado", {12'h0, bus_if.db_estado}, 16'd1);
      reset = 1'b1;
      #1;
      check_all_zero("reset_meio");
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      pulse_cnt = 0;
      hold(16'h0010, 1'b1, 12);
      checkOutput("pos_reset_pulsos", 16'(pulse_cnt), 16'd1);
      checkOutput("pos_reset_codigo", {12'h0, bus_if.jogada_codigo}, 16'd4);
      applyStimulus(16'h0010, 1'b1, 1'b1);
      checkOutput("zera_jogada", bus_if.jogada, 16'h0);
      checkOutput("zera_codigo", {12'h0, bus_if.jogada_codigo}, 16'd0);
      checkOutput("zera_estado", {12'h0, bus_if.db_estado}, 16'd3);
      hold(16'h0, 1'b1, 10);

      // Randomized traffic against the model.
      for (int seg = 0; seg < 80; seg++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 3)      v = 16'h0;
         else if (sel <= 7) v = one << $urandom_range(0, 15);
         else if (sel == 8) v = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
         else               v = 16'($urandom);
         h   = ($urandom_range(0, 7) != 0);
         len = $urandom_range(1, 9);
         for (int c = 0; c < len; c++) begin
            z = ($urandom_range(0, 19) == 0);
            applyStimulus(v, h, z);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
